// File: rtl/cpu_run_ctrl.sv
// Run-control front end: debounced buttons select the CPU execution mode and
// debug page, and drive work_ena plus a scanned active-low seven-segment display.
module cpu_run_ctrl #(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned NUM_PAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SCAN_CYCLES     = 100000,
    parameter int unsigned AUTO_PERIOD     = 50000000,
    localparam int unsigned PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_btn_c,
    input  logic                              i_btn_u,
    input  logic                              i_btn_d,
    input  logic                              i_btn_l,
    input  logic                              i_btn_r,
    input  logic [NUM_PAGES*4*NUM_DIGITS-1:0] i_disp_bus,
    output logic                              o_work_ena,
    output logic [1:0]                        o_mode,
    output logic [PAGE_W-1:0]                 o_page,
    output logic [31:0]                       o_exec_count,
    output logic [NUM_DIGITS-1:0]             o_seg_an,
    output logic [7:0]                        o_seg_seg
);
    localparam int unsigned NB        = 5;
    localparam int unsigned BTN_C     = 0;
    localparam int unsigned BTN_U     = 1;
    localparam int unsigned BTN_D     = 2;
    localparam int unsigned BTN_L     = 3;
    localparam int unsigned BTN_R     = 4;
    localparam int unsigned DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SC_W      = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned AU_W      = $clog2(AUTO_PERIOD);
    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PAGE_BITS = 4 * NUM_DIGITS;

    localparam logic [1:0] MODE_HALT = 2'd0;
    localparam logic [1:0] MODE_STEP = 2'd1;
    localparam logic [1:0] MODE_AUTO = 2'd2;
    localparam logic [1:0] MODE_RUN  = 2'd3;

    logic [NB-1:0] w_btn_raw;
    logic [NB-1:0] w_press;

    assign w_btn_raw = {i_btn_r, i_btn_l, i_btn_d, i_btn_u, i_btn_c};

    // Per-button synchroniser, debounce counter and rising-edge press pulse
    for (genvar g = 0; g < NB; g++) begin : g_btn
        logic            r_sync1;
        logic            r_sync2;
        logic            r_level;
        logic            r_press;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn_raw[g];
                r_sync2 <= r_sync1;
                r_press <= 1'b0;
                if (r_sync2 != r_level) begin
                    if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_level <= r_sync2;
                        r_press <= r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + DB_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_press[g] = r_press;
    end

    logic [1:0]        r_mode;
    logic [1:0]        w_mode_nxt;
    logic              r_work_ena;
    logic              w_work_ena_nxt;
    logic [AU_W-1:0]   r_auto_cnt;
    logic [31:0]       r_exec_count;
    logic [PAGE_W-1:0] r_page;

    // Mode state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_mode <= MODE_HALT;
        else       r_mode <= w_mode_nxt;
    end

    // Next mode: halt wins over next-mode
    always_comb begin
        w_mode_nxt = r_mode;
        if (w_press[BTN_D])      w_mode_nxt = MODE_HALT;
        else if (w_press[BTN_U]) w_mode_nxt = r_mode + 2'd1;
    end

    // work_ena cause; suppressed in any cycle where the mode is changing
    always_comb begin
        w_work_ena_nxt = 1'b0;
        if (w_mode_nxt == r_mode) begin
            case (r_mode)
                MODE_STEP: w_work_ena_nxt = w_press[BTN_C];
                MODE_AUTO: w_work_ena_nxt = (r_auto_cnt == AU_W'(AUTO_PERIOD - 1));
                MODE_RUN:  w_work_ena_nxt = 1'b1;
                default:   w_work_ena_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_work_ena   <= 1'b0;
            r_auto_cnt   <= '0;
            r_exec_count <= '0;
            r_page       <= '0;
        end else begin
            r_work_ena   <= w_work_ena_nxt;
            r_exec_count <= r_exec_count + 32'(r_work_ena);
            if (r_mode != MODE_AUTO || r_auto_cnt == AU_W'(AUTO_PERIOD - 1))
                r_auto_cnt <= '0;
            else
                r_auto_cnt <= r_auto_cnt + AU_W'(1);
            if (w_press[BTN_R] && !w_press[BTN_L])
                r_page <= (r_page == PAGE_W'(NUM_PAGES - 1)) ? '0 : r_page + PAGE_W'(1);
            else if (w_press[BTN_L] && !w_press[BTN_R])
                r_page <= (r_page == '0) ? PAGE_W'(NUM_PAGES - 1) : r_page - PAGE_W'(1);
        end
    end

    logic [SC_W-1:0]      r_scan_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_DIGITS-1:0] r_seg_an;
    logic [7:0]           r_seg_seg;
    logic [PAGE_BITS-1:0] w_page_word;
    logic [3:0]           w_nibble;
    logic [6:0]           w_glyph;
    logic                 w_dp_n;

    always_comb begin
        w_page_word = '0;
        for (int p = 0; p < int'(NUM_PAGES); p++)
            if (int'(r_page) == p) w_page_word = i_disp_bus[p*PAGE_BITS +: PAGE_BITS];
    end

    always_comb begin
        w_nibble = '0;
        for (int d = 0; d < int'(NUM_DIGITS); d++)
            if (int'(r_idx) == d) w_nibble = w_page_word[d*4 +: 4];
    end

    // Active-low {g,f,e,d,c,b,a} hex glyphs
    always_comb begin
        case (w_nibble)
            4'h0:    w_glyph = 7'b1000000;
            4'h1:    w_glyph = 7'b1111001;
            4'h2:    w_glyph = 7'b0100100;
            4'h3:    w_glyph = 7'b0110000;
            4'h4:    w_glyph = 7'b0011001;
            4'h5:    w_glyph = 7'b0010010;
            4'h6:    w_glyph = 7'b0000010;
            4'h7:    w_glyph = 7'b1111000;
            4'h8:    w_glyph = 7'b0000000;
            4'h9:    w_glyph = 7'b0010000;
            4'hA:    w_glyph = 7'b0001000;
            4'hB:    w_glyph = 7'b0000011;
            4'hC:    w_glyph = 7'b1000110;
            4'hD:    w_glyph = 7'b0100001;
            4'hE:    w_glyph = 7'b0000110;
            default: w_glyph = 7'b0001110;
        endcase
    end

    // The decimal point marks the digit whose index equals the current mode
    assign w_dp_n = (int'(r_idx) != int'(r_mode));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_seg_an   <= '1;
            r_seg_seg  <= 8'hFF;
        end else begin
            r_seg_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg_seg <= {w_dp_n, w_glyph};
            if (r_scan_cnt == SC_W'(SCAN_CYCLES - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + SC_W'(1);
            end
        end
    end

    assign o_work_ena   = r_work_ena;
    assign o_mode       = r_mode;
    assign o_page       = r_page;
    assign o_exec_count = r_exec_count;
    assign o_seg_an     = r_seg_an;
    assign o_seg_seg    = r_seg_seg;

endmodule
